// File: rtl/parity_scan_ctrl_pkg.sv
// Shared types and constants for the parity scan controller.
// Holds the FSM state encoding, check-mode codes and datapath/counter widths.
package parity_scan_ctrl_pkg;

  localparam int DATA_W     = 8;
  localparam int SYN_W      = 4;
  localparam int BYTE_CNT_W = 16;
  localparam int ERR_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef logic [1:0] chk_t;

  localparam chk_t CHK_HI_NIB   = 2'd0;
  localparam chk_t CHK_EVEN_POS = 2'd1;
  localparam chk_t CHK_ODD_POS  = 2'd2;
  localparam chk_t CHK_ALL      = 2'd3;

endpackage

// File: rtl/parity_scan_ctrl_sel.sv
// Combinational per-mode parity evaluation: picks one bit group of the byte,
// XOR-reduces it and inverts the result when even-parity sense is selected.
module parity_sel_unit
  import parity_scan_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] d_i,
  input  chk_t              chk_i,
  input  logic              even_i,
  output logic              y_o
);

  logic sel;

  always_comb begin
    sel = 1'b0;
    case (chk_i)
      CHK_HI_NIB:   sel = ^d_i[7:4];
      CHK_EVEN_POS: sel = d_i[0] ^ d_i[2] ^ d_i[4] ^ d_i[6];
      CHK_ODD_POS:  sel = d_i[1] ^ d_i[3] ^ d_i[5] ^ d_i[7];
      default:      sel = ^d_i;
    endcase
    y_o = sel ^ even_i;
  end

endmodule

// File: rtl/parity_scan_ctrl.sv
// Byte parity scanner: accepts a byte, evaluates four parity modes one per
// cycle into a syndrome, holds the result for the consumer and keeps counters.
module parity_scan_ctrl
  import parity_scan_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_even,
  input  logic                  in_check_en,
  input  logic [SYN_W-1:0]      in_expect,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [SYN_W-1:0]      out_syndrome,
  output logic                  out_err,
  output logic                  busy,
  input  logic                  cnt_clr,
  output logic [BYTE_CNT_W-1:0] byte_cnt,
  output logic [ERR_CNT_W-1:0]  err_cnt
);

  state_e                state_q, state_d;
  chk_t                  chk_q, chk_d;
  logic [SYN_W-1:0]      syn_q, syn_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  even_q, even_d;
  logic                  chken_q, chken_d;
  logic [SYN_W-1:0]      expect_q, expect_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic                  y;
  logic                  hs;

  function automatic logic [ERR_CNT_W-1:0] err_sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : ERR_CNT_W'(v + 1'b1);
  endfunction

  parity_sel_unit u_sel (
    .d_i    (data_q),
    .chk_i  (chk_q),
    .even_i (even_q),
    .y_o    (y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      chk_q      <= CHK_HI_NIB;
      syn_q      <= '0;
      data_q     <= '0;
      even_q     <= 1'b0;
      chken_q    <= 1'b0;
      expect_q   <= '0;
      byte_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      chk_q      <= chk_d;
      syn_q      <= syn_d;
      data_q     <= data_d;
      even_q     <= even_d;
      chken_q    <= chken_d;
      expect_q   <= expect_d;
      byte_cnt_q <= byte_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    chk_d     = chk_q;
    syn_d     = syn_q;
    data_d    = data_q;
    even_d    = even_q;
    chken_d   = chken_q;
    expect_d  = expect_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d   = in_data;
          even_d   = in_even;
          chken_d  = in_check_en;
          expect_d = in_expect;
          chk_d    = CHK_HI_NIB;
          syn_d    = '0;
          state_d  = ST_SCAN;
        end
      end
      ST_SCAN: begin
        syn_d[chk_q] = y;
        chk_d        = chk_t'(chk_q + 1'b1);
        if (chk_q == CHK_ALL) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    out_err = out_valid & chken_q & (syn_q != expect_q);
    hs      = out_valid & out_ready;

    // Clear takes priority over a coincident result handshake.
    byte_cnt_d = byte_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (cnt_clr) begin
      byte_cnt_d = '0;
      err_cnt_d  = '0;
    end else if (hs) begin
      byte_cnt_d = BYTE_CNT_W'(byte_cnt_q + 1'b1);
      if (out_err) err_cnt_d = err_sat_inc(err_cnt_q);
    end
  end

  assign out_data     = data_q;
  assign out_syndrome = syn_q;
  assign busy         = (state_q != ST_IDLE);
  assign byte_cnt     = byte_cnt_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_parity_scan_ctrl.sv
// Self-checking bench for parity_scan_ctrl with a mask/popcount reference model.
module tb_parity_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_even;
  logic        in_check_en;
  logic [3:0]  in_expect;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [3:0]  out_syndrome;
  logic        out_err;
  logic        busy;
  logic        cnt_clr;
  logic [15:0] byte_cnt;
  logic [7:0]  err_cnt;

  int nchk = 0;
  int nerr = 0;
  int mdl_bytes = 0;
  int mdl_errs  = 0;

  parity_scan_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_even(in_even), .in_check_en(in_check_en), .in_expect(in_expect),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_syndrome(out_syndrome), .out_err(out_err), .busy(busy),
    .cnt_clr(cnt_clr), .byte_cnt(byte_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit k of the syndrome is the parity of the byte under mask k, inverted for even sense.
  function automatic logic [3:0] ref_syn(input logic [7:0] d, input logic ev);
    logic [31:0] masks;
    logic [3:0]  r;
    masks = 32'hFFAA55F0;
    for (int k = 0; k < 4; k++)
      r[k] = (($countones(d & masks[k*8 +: 8]) % 2) == 1) ^ ev;
    return r;
  endfunction

  task automatic check_counters(input string tag);
    check_eq({tag, ".byte_cnt"}, 32'(byte_cnt), 32'(mdl_bytes & 16'hFFFF));
    check_eq({tag, ".err_cnt"},  32'(err_cnt),  32'(mdl_errs));
  endtask

  task automatic run_byte(input logic [7:0] d, input logic ev, input logic ce,
                          input logic [3:0] ex, input int hold, input logic clr_hs);
    logic [3:0] syn;
    logic       err;
    int         w;
    syn = ref_syn(d, ev);
    err = ce && (syn != ex);
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    check_eq("start.in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = d; in_even = ev; in_check_en = ce; in_expect = ex;
    tick();
    in_valid = 1'b0; in_data = $urandom; in_even = $urandom; in_expect = $urandom;
    check_eq("accept.busy", 32'(busy), 32'd1);
    check_eq("accept.in_ready", 32'(in_ready), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_eq("scan.out_valid", 32'(out_valid), 32'd0);
      check_eq("scan.out_err", 32'(out_err), 32'd0);
      check_eq("scan.partial_syn", 32'(out_syndrome), 32'(syn & 4'((1 << i) - 1)));
    end
    tick();
    check_eq("done.out_valid", 32'(out_valid), 32'd1);
    check_eq("done.syndrome", 32'(out_syndrome), 32'(syn));
    check_eq("done.out_err", 32'(out_err), 32'(err));
    check_eq("done.out_data", 32'(out_data), 32'(d));
    for (int i = 0; i < hold; i++) begin
      if (i == hold / 2) begin
        in_valid = 1'b1; in_data = ~d;
      end
      tick();
      check_eq("hold.out_valid", 32'(out_valid), 32'd1);
      check_eq("hold.in_ready", 32'(in_ready), 32'd0);
      check_eq("hold.out_data", 32'(out_data), 32'(d));
      check_eq("hold.syndrome", 32'(out_syndrome), 32'(syn));
      check_eq("hold.out_err", 32'(out_err), 32'(err));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cnt_clr = clr_hs;
    tick();
    out_ready = 1'b0;
    cnt_clr = 1'b0;
    if (clr_hs) begin
      mdl_bytes = 0;
      mdl_errs  = 0;
    end else begin
      mdl_bytes++;
      if (err && mdl_errs < 255) mdl_errs++;
    end
    check_eq("post.in_ready", 32'(in_ready), 32'd1);
    check_eq("post.out_valid", 32'(out_valid), 32'd0);
    check_eq("post.busy", 32'(busy), 32'd0);
    check_counters("post");
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_even = 1'b0; in_check_en = 1'b0;
    in_expect = '0; out_ready = 1'b0; cnt_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_eq("rst.in_ready", 32'(in_ready), 32'd1);
    check_eq("rst.out_valid", 32'(out_valid), 32'd0);
    check_eq("rst.out_err", 32'(out_err), 32'd0);
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.out_data", 32'(out_data), 32'd0);
    check_eq("rst.syndrome", 32'(out_syndrome), 32'd0);
    check_counters("rst");

    // Directed cases: A5 zero syndrome, 01 odd/even, check_en match/mismatch, long hold.
    run_byte(8'hA5, 1'b0, 1'b0, 4'h0, 0, 1'b0);
    run_byte(8'h01, 1'b0, 1'b0, 4'h0, 0, 1'b0);
    check_eq("ref.01_odd", 32'(ref_syn(8'h01, 1'b0)), 32'hA);
    run_byte(8'h01, 1'b1, 1'b0, 4'h0, 0, 1'b0);
    run_byte(8'h01, 1'b0, 1'b1, 4'hA, 0, 1'b0);
    run_byte(8'h01, 1'b0, 1'b1, 4'h3, 0, 1'b0);
    run_byte(8'h3C, 1'b1, 1'b1, 4'h7, 10, 1'b0);

    for (int n = 0; n < 24; n++)
      run_byte(8'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
               int'($urandom_range(0, 3)), 1'b0);

    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    mdl_bytes = 0; mdl_errs = 0;
    check_counters("clr");

    // Drive err_cnt to saturation, then past it, then clear on a handshake edge.
    for (int n = 0; n < 256; n++)
      run_byte(8'h01, 1'b0, 1'b1, 4'h3, 0, 1'b0);
    check_eq("sat.err_cnt", 32'(err_cnt), 32'hFF);
    run_byte(8'h80, 1'b1, 1'b1, 4'h0, 0, 1'b0);
    check_eq("sat.err_cnt_hold", 32'(err_cnt), 32'hFF);
    run_byte(8'h01, 1'b0, 1'b1, 4'h3, 0, 1'b1);

    // Reset while scanning with chk at 2.
    run_byte(8'h5A, 1'b0, 1'b0, 4'h0, 0, 1'b0);
    in_valid = 1'b1; in_data = 8'hC3; in_check_en = 1'b1; in_expect = 4'h0;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mdl_bytes = 0; mdl_errs = 0;
    check_eq("rstscan.in_ready", 32'(in_ready), 32'd1);
    check_eq("rstscan.out_valid", 32'(out_valid), 32'd0);
    check_eq("rstscan.busy", 32'(busy), 32'd0);
    check_eq("rstscan.syndrome", 32'(out_syndrome), 32'd0);
    check_counters("rstscan");

    // Reset in DONE beats a handshake on the same edge.
    in_valid = 1'b1; in_data = 8'h01; in_check_en = 1'b1; in_expect = 4'h3;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_eq("rstdone.out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1; rst = 1'b1;
    tick();
    out_ready = 1'b0; rst = 1'b0;
    check_eq("rstdone.in_ready", 32'(in_ready), 32'd1);
    check_eq("rstdone.out_data", 32'(out_data), 32'd0);
    check_counters("rstdone");

    run_byte(8'hFF, 1'b0, 1'b1, 4'h0, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/parity_scan_ctrl.md
PARITY_SCAN_CTRL -- requirements
Module: parity_scan_ctrl

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 in_valid  in  1  byte offered.
REQ-005 in_ready  out  1  block accepts byte this cycle.
REQ-006 in_data  in  8  byte to scan.
REQ-007 in_even  in  1  1 = even-parity sense, 0 = odd-parity sense; captured with byte.
REQ-008 in_check_en  in  1  1 = compare syndrome against in_expect; captured with byte.
REQ-009 in_expect  in  4  expected syndrome; captured with byte.
REQ-010 out_valid  out  1  result held for consumer.
REQ-011 out_ready  in  1  consumer takes result.
REQ-012 out_data  out  8  captured byte.
REQ-013 out_syndrome  out  4  bit k = parity result for check mode k.
REQ-014 out_err  out  1  check_en & (syndrome != expect).
REQ-015 busy  out  1  high in any state but IDLE.
REQ-016 cnt_clr  in  1  synchronous clear of both counters.
REQ-017 byte_cnt  out  16  results delivered, wraps 16'hFFFF -> 0.
REQ-018 err_cnt  out  8  results delivered with out_err=1, saturates at 8'hFF.

Function
REQ-019 Check mode k (2-bit chk) SHALL select: 0 = XOR of D[7:4]; 1 = XOR of D[0],D[2],D[4],D[6]; 2 = XOR of D[1],D[3],D[5],D[7]; 3 = XOR of D[7:0].
REQ-020 Per-mode result SHALL be Y = selected XOR when even=0, and its inverse when even=1.
REQ-021 FSM states SHALL be IDLE, SCAN, DONE.
REQ-022 IDLE: in_ready=1; in_valid=1 at the edge -> capture data/even/check_en/expect, chk<=0, go to SCAN.
REQ-023 SCAN: one mode per cycle; at each edge syndrome[chk]<=Y, chk<=chk+1; the edge with chk=3 goes to DONE.
REQ-024 Latency: out_valid SHALL assert exactly 5 edges after the accepting edge (accept edge + 4 SCAN edges), i.e. the 5th cycle after acceptance.
REQ-025 DONE: out_valid=1, outputs stable; out_ready=1 at the edge -> IDLE, byte_cnt+1, err_cnt+1 (saturating) if out_err.
REQ-026 in_ready SHALL be 0 in SCAN and DONE; in_valid is ignored there.
REQ-027 out_syndrome bits not yet written in SCAN SHALL read 0; out_valid gates validity.
REQ-028 out_err SHALL be 0 whenever check_en captured 0 or out_valid=0.
REQ-029 cnt_clr coincident with an output handshake: clear wins, both counters read 0 after the edge.
REQ-030 Max throughput: one byte per 6 cycles with out_ready held high.

Reset
REQ-031 rst SHALL force state IDLE, chk=0, syndrome=0, captured data/flags/expect=0, byte_cnt=0, err_cnt=0.
REQ-032 Reset values: in_ready=1, out_valid=0, out_err=0, busy=0, out_data=0, out_syndrome=0.
REQ-033 rst mid-SCAN or in DONE SHALL discard the byte; no counter update; rst wins over any handshake.

Structure
REQ-034 A shared package SHALL hold the FSM state enum (IDLE/SCAN/DONE), the chk mode constants (CHK_HI_NIB=0, CHK_EVEN_POS=1, CHK_ODD_POS=2, CHK_ALL=3), and the counter widths.
REQ-035 The combinational per-mode parity evaluation (REQ-019/020) SHALL be one sub-module, parity_sel_unit (in D[7:0], chk[1:0], even; out Y), instantiated once.

Verification
REQ-036 rst, then in_data=8'hA5, in_even=0, check_en=0 -> out_syndrome=4'h0, out_err=0, out_valid in 5th cycle after accept.
REQ-037 in_data=8'h01, in_even=0 -> syndrome 4'hA; same byte with in_even=1 -> syndrome 4'h5.
REQ-038 in_data=8'h01, in_even=0, check_en=1, expect=4'hA -> out_err=0; expect=4'h3 -> out_err=1, err_cnt increments.
REQ-039 out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready=0, second in_valid ignored; out_ready=1 -> byte_cnt+1, IDLE.
REQ-040 Preload err_cnt=8'hFF via 255 errors -> further errors keep 8'hFF; cnt_clr with handshake same edge -> both 0.
REQ-041 rst asserted during SCAN (chk=2) -> next cycle IDLE, out_valid=0, in_ready=1, counters unchanged (0).
